// File: rtl/tage_update_unit.sv
// TAGE update consumer: queues resolved-branch update packets from the FTQ and
// serialises each one into provider, allocation and useful-decrement writes on
// the single shared table write port.
module tage_update_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDXW  = 8,
  parameter int unsigned TAGW  = 8
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            UpdFlush,
  input  logic            InDateAble,
  input  logic [31:0]     InUpDatePc,
  input  logic [2:0]      InUpNum,
  input  logic [2:0]      InUpDate,
  input  logic [2:0]      InUpCnt,
  input  logic            InNewAble,
  input  logic [2:0]      InNewNum,
  input  logic [2:0]      InNewDate,
  input  logic [2:0]      InNewCnt,
  input  logic [5:0]      InCntAble,
  input  logic [17:0]     InCntDate,
  output logic            UpdFull,
  output logic            UpdDrop,
  output logic            UpdBusy,
  input  logic            TblReady,
  output logic            TblWe,
  output logic [2:0]      TblSel,
  output logic [IDXW-1:0] TblIdx,
  output logic [TAGW-1:0] TblTag,
  output logic [2:0]      TblCtr,
  output logic [2:0]      TblUse,
  output logic [2:0]      TblMask
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = PTRW + 1;
  localparam int unsigned PCHI = TAGW + 2 * IDXW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  up_num;
    logic [2:0]  up_date;
    logic [2:0]  up_cnt;
    logic        new_able;
    logic [2:0]  new_num;
    logic [2:0]  new_date;
    logic [2:0]  new_cnt;
    logic [5:0]  cnt_able;
    logic [17:0] cnt_date;
  } upd_pkt_t;

  typedef enum logic [1:0] {S_IDLE, S_PROV, S_ALLOC, S_DEC} state_e;

  upd_pkt_t  mem_q [DEPTH];
  upd_pkt_t  head;
  upd_pkt_t  pkt_in;
  state_e    state_q, state_d;
  logic [5:0]      pend_q, pend_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PTRW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic            drop_q, drop_d;
  logic            push, pop, act, xfer;
  logic [2:0]      dec_bit;
  logic [2:0]      sel, ctr, use_v, mask;
  logic [IDXW-1:0] base;
  logic            unused_pc;

  assign head   = mem_q[rd_q];
  assign pkt_in = '{pc: InUpDatePc, up_num: InUpNum, up_date: InUpDate, up_cnt: InUpCnt,
                    new_able: InNewAble, new_num: InNewNum, new_date: InNewDate,
                    new_cnt: InNewCnt, cnt_able: InCntAble, cnt_date: InCntDate};

  // Lowest pending useful-decrement table (descending scan so the lowest wins)
  always_comb begin
    dec_bit = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pend_q[i]) dec_bit = 3'(i);
    end
  end

  // Write payload for the current state; zero while idle or in reset
  always_comb begin
    sel   = 3'd0;
    ctr   = 3'd0;
    use_v = 3'd0;
    mask  = 3'd0;
    unique case (state_q)
      S_PROV: begin
        sel   = head.up_num;
        ctr   = head.up_date;
        use_v = head.up_cnt;
        mask  = (head.up_num == 3'd0) ? 3'b001 : 3'b011;
      end
      S_ALLOC: begin
        sel   = head.new_num;
        ctr   = head.new_date;
        use_v = head.new_cnt;
        mask  = 3'b111;
      end
      S_DEC: begin
        sel   = dec_bit + 3'd1;
        use_v = head.cnt_date[3*dec_bit +: 3];
        mask  = 3'b010;
      end
      default: ;
    endcase
  end

  assign act       = Rest & (state_q != S_IDLE);
  assign base      = head.pc[IDXW+1:2] ^ head.pc[2*IDXW+1:IDXW+2];
  assign TblWe     = act & ~UpdFlush;
  assign xfer      = TblWe & TblReady;
  assign TblSel    = act ? sel : 3'd0;
  assign TblCtr    = act ? ctr : 3'd0;
  assign TblUse    = act ? use_v : 3'd0;
  assign TblMask   = act ? mask : 3'd0;
  assign TblIdx    = act ? (base ^ IDXW'(sel)) : '0;
  assign TblTag    = act ? head.pc[PCHI:2*IDXW+2] : '0;
  assign UpdFull   = Rest & (cnt_q == CNTW'(DEPTH));
  assign UpdBusy   = Rest & ((cnt_q != '0) | (state_q != S_IDLE));
  assign UpdDrop   = Rest & drop_q;
  assign unused_pc = ^{head.pc[31:PCHI+1], head.pc[1:0]};

  // Next-state: packet sequencing, queue bookkeeping, flush override
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pop     = 1'b0;
    unique case (state_q)
      S_PROV: if (xfer) begin
        pend_d = head.cnt_able;
        if (head.new_able)             state_d = S_ALLOC;
        else if (head.cnt_able != '0)  state_d = S_DEC;
        else                           pop = 1'b1;
      end
      S_ALLOC: if (xfer) begin
        if (pend_q != '0) state_d = S_DEC;
        else              pop = 1'b1;
      end
      S_DEC: if (xfer) begin
        pend_d = pend_q & ~(6'b1 << dec_bit);
        if (pend_d == '0) pop = 1'b1;
      end
      default: ;
    endcase
    push   = InDateAble & ((cnt_q != CNTW'(DEPTH)) | pop) & ~UpdFlush;
    drop_d = InDateAble & ~push & ~UpdFlush;
    cnt_d  = cnt_q + CNTW'(push) - CNTW'(pop);
    wr_d   = wr_q + PTRW'(push);
    rd_d   = rd_q + PTRW'(pop);
    if (pop || state_q == S_IDLE) state_d = (cnt_d != '0) ? S_PROV : S_IDLE;
    if (UpdFlush) begin
      state_d = S_IDLE;
      pend_d  = '0;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rest) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      drop_q  <= drop_d;
    end
  end

  // Packet storage
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_q] <= pkt_in;
  end

endmodule

// File: tb/tb_tage_update_unit.sv
// Bench for tage_update_unit: directed scenarios then random traffic, all
// compared cycle by cycle against a packet-list reference model.
module tb_tage_update_unit;

  localparam int DEPTH = 4;
  localparam int IDXW  = 8;
  localparam int TAGW  = 8;

  logic Clk = 1'b0;
  logic Rest, UpdFlush, InDateAble, InNewAble, TblReady;
  logic [31:0] InUpDatePc;
  logic [2:0]  InUpNum, InUpDate, InUpCnt, InNewNum, InNewDate, InNewCnt;
  logic [5:0]  InCntAble;
  logic [17:0] InCntDate;
  logic UpdFull, UpdDrop, UpdBusy, TblWe;
  logic [2:0] TblSel, TblCtr, TblUse, TblMask;
  logic [IDXW-1:0] TblIdx;
  logic [TAGW-1:0] TblTag;

  always #5 Clk = ~Clk;

  tage_update_unit #(.DEPTH(DEPTH), .IDXW(IDXW), .TAGW(TAGW)) dut (
    .Clk(Clk), .Rest(Rest), .UpdFlush(UpdFlush), .InDateAble(InDateAble),
    .InUpDatePc(InUpDatePc), .InUpNum(InUpNum), .InUpDate(InUpDate), .InUpCnt(InUpCnt),
    .InNewAble(InNewAble), .InNewNum(InNewNum), .InNewDate(InNewDate), .InNewCnt(InNewCnt),
    .InCntAble(InCntAble), .InCntDate(InCntDate), .UpdFull(UpdFull), .UpdDrop(UpdDrop),
    .UpdBusy(UpdBusy), .TblReady(TblReady), .TblWe(TblWe), .TblSel(TblSel), .TblIdx(TblIdx),
    .TblTag(TblTag), .TblCtr(TblCtr), .TblUse(TblUse), .TblMask(TblMask)
  );

  typedef struct {
    logic [31:0] pc;
    int up_num, up_date, up_cnt, new_able, new_num, new_date, new_cnt, cnt_able, cnt_date;
  } pkt_t;

  typedef struct { int sel, ctr, uval, mask; } wr_t;

  pkt_t mq[$];
  int   wr_done;
  bit   drop_exp;
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int n_writes(pkt_t p);
    return 1 + p.new_able + $countones(p.cnt_able);
  endfunction

  // k-th table write of a packet: provider, optional allocation, then decrements
  function automatic wr_t get_wr(pkt_t p, int k);
    wr_t w;
    int j;
    if (k == 0) begin
      w = '{p.up_num, p.up_date, p.up_cnt, (p.up_num == 0) ? 1 : 3};
      return w;
    end
    if (k == 1 && p.new_able == 1) begin
      w = '{p.new_num, p.new_date, p.new_cnt, 7};
      return w;
    end
    j = k - 1 - p.new_able;
    w = '{0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      if ((p.cnt_able >> i) & 1) begin
        if (j == 0) begin
          w = '{i + 1, 0, (p.cnt_date >> (3 * i)) & 7, 2};
          return w;
        end
        j--;
      end
    end
    return w;
  endfunction

  function automatic pkt_t cur_inputs();
    pkt_t p;
    p.pc = InUpDatePc; p.up_num = InUpNum; p.up_date = InUpDate; p.up_cnt = InUpCnt;
    p.new_able = InNewAble; p.new_num = InNewNum; p.new_date = InNewDate; p.new_cnt = InNewCnt;
    p.cnt_able = InCntAble; p.cnt_date = InCntDate;
    return p;
  endfunction

  task automatic compare_outputs();
    wr_t w;
    int idx, tag;
    if (!Rest) begin
      check_eq("rst_we", TblWe, 0);    check_eq("rst_sel", TblSel, 0);
      check_eq("rst_idx", TblIdx, 0);  check_eq("rst_tag", TblTag, 0);
      check_eq("rst_ctr", TblCtr, 0);  check_eq("rst_use", TblUse, 0);
      check_eq("rst_mask", TblMask, 0); check_eq("rst_full", UpdFull, 0);
      check_eq("rst_drop", UpdDrop, 0); check_eq("rst_busy", UpdBusy, 0);
      return;
    end
    check_eq("full", UpdFull, 32'(mq.size() == DEPTH));
    check_eq("busy", UpdBusy, 32'(mq.size() != 0));
    check_eq("drop", UpdDrop, 32'(drop_exp));
    check_eq("we", TblWe, 32'(mq.size() != 0 && !UpdFlush));
    if (mq.size() != 0) begin
      w   = get_wr(mq[0], wr_done);
      idx = int'(((mq[0].pc >> 2) ^ (mq[0].pc >> (IDXW + 2)) ^ 32'(w.sel)) & ((1 << IDXW) - 1));
      tag = int'((mq[0].pc >> (2 * IDXW + 2)) & ((1 << TAGW) - 1));
      check_eq("sel", TblSel, w.sel);   check_eq("idx", TblIdx, idx);
      check_eq("tag", TblTag, tag);     check_eq("ctr", TblCtr, w.ctr);
      check_eq("use", TblUse, w.uval);  check_eq("mask", TblMask, w.mask);
    end
  endtask

  task automatic model_edge();
    if (!Rest || UpdFlush) begin
      mq.delete(); wr_done = 0; drop_exp = 0;
      return;
    end
    if (mq.size() != 0 && TblReady) begin
      wr_done++;
      if (wr_done == n_writes(mq[0])) begin
        void'(mq.pop_front());
        wr_done = 0;
      end
    end
    drop_exp = 0;
    if (InDateAble) begin
      if (mq.size() < DEPTH) mq.push_back(cur_inputs());
      else drop_exp = 1;
    end
  endtask

  task automatic step();
    @(negedge Clk);
    compare_outputs();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic set_pkt(input logic [31:0] pc, input int un, input int ud, input int uc,
                         input int na, input int nn, input int nd, input int nc,
                         input int ca, input int cd);
    InUpDatePc = pc; InUpNum = 3'(un); InUpDate = 3'(ud); InUpCnt = 3'(uc);
    InNewAble = 1'(na); InNewNum = 3'(nn); InNewDate = 3'(nd); InNewCnt = 3'(nc);
    InCntAble = 6'(ca); InCntDate = 18'(cd);
  endtask

  task automatic rand_pkt();
    set_pkt($urandom, $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(1, 6), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 262143));
  endtask

  initial begin
    Rest = 0; UpdFlush = 0; InDateAble = 0; TblReady = 1;
    wr_done = 0; drop_exp = 0;
    set_pkt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); @(posedge Clk); #1;
    step();
    Rest = 1;
    step();

    // single provider write, then idle
    set_pkt(32'h0000_1234, 2, 5, 3, 0, 0, 0, 0, 0, 0);
    InDateAble = 1; step(); InDateAble = 0;
    repeat (3) step();

    // base provider + allocation + three decrements
    set_pkt(32'h0BAD_F00D, 0, 6, 1, 1, 4, 4, 2, 6'b100101, 18'o654321);
    InDateAble = 1; step(); InDateAble = 0;
    repeat (6) step();

    // fill with port stalled, overflow one, then drain
    TblReady = 0; InDateAble = 1;
    for (int i = 0; i < 5; i++) begin
      rand_pkt(); step();
    end
    InDateAble = 0;
    repeat (2) step();
    TblReady = 1;
    repeat (30) step();

    // stalls in the middle of a multi-write packet
    set_pkt(32'h1357_9BDF, 0, 6, 1, 1, 4, 4, 2, 6'b100101, 18'o123456);
    InDateAble = 1; step(); InDateAble = 0;
    TblReady = 1; step(); TblReady = 0; step(); step(); TblReady = 1;
    repeat (6) step();

    // flush with three queued packets
    InDateAble = 1;
    for (int i = 0; i < 3; i++) begin
      rand_pkt(); InNewAble = 1; step();
    end
    InDateAble = 0; UpdFlush = 1; step(); UpdFlush = 0;
    repeat (4) step();

    // reset in the middle of decrements, then a fresh packet
    set_pkt(32'h2468_ACE0, 3, 1, 1, 1, 5, 2, 2, 6'b111111, 18'o777777);
    InDateAble = 1; step(); InDateAble = 0;
    repeat (3) step();
    Rest = 0; step(); Rest = 1;
    step();
    set_pkt(32'h0000_1234, 2, 5, 3, 0, 0, 0, 0, 6'b000010, 18'o000070);
    InDateAble = 1; step(); InDateAble = 0;
    repeat (4) step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rand_pkt();
      InDateAble = 1'($urandom_range(0, 99) < 45);
      TblReady   = 1'($urandom_range(0, 99) < 70);
      UpdFlush   = 1'($urandom_range(0, 99) < 2);
      Rest       = 1'($urandom_range(0, 99) >= 1);
      step();
    end
    Rest = 1; UpdFlush = 0; InDateAble = 0; TblReady = 1;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
